// File: rtl/s2p_param.sv
// Serial-to-parallel converter: gathers WIDTH sampled bits into a word and
// offers it through a registered valid/ready stage with overflow/abort flags.
module s2p_param #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s2p_en,
    input  logic             data_in,
    input  logic             data_out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    output logic             overflow,
    output logic             frame_abort
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("s2p_param: WIDTH must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CNT_W-1:0] cnt;
    logic             complete;
    logic             accept;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sh_next = {sh[WIDTH-2:0], data_in};
        end else begin : g_lsb_first
            assign sh_next = {data_in, sh[WIDTH-1:1]};
        end
    endgenerate

    // The completed word is the shift value that includes the current bit.
    assign complete = s2p_en && (cnt == LAST);
    assign accept   = data_out_valid && data_out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh             <= '0;
            cnt            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overflow       <= 1'b0;
            frame_abort    <= 1'b0;
        end else begin
            overflow    <= 1'b0;
            frame_abort <= 1'b0;

            if (s2p_en) begin
                sh  <= sh_next;
                cnt <= complete ? '0 : cnt + CNT_W'(1);
            end else begin
                sh  <= '0;
                cnt <= '0;
                if (cnt != '0) begin
                    frame_abort <= 1'b1;
                end
            end

            // A held word is only replaced when the consumer takes it this edge.
            if (complete) begin
                if (!data_out_valid || accept) begin
                    data_out       <= sh_next;
                    data_out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (accept) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p_param.sv
// Scoreboard bench for s2p_param: three configurations share one stimulus
// stream and are checked against a bit-list reference model.
module tb_s2p_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       din;
    logic       rdy;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] d2;
    logic [2:0] v;
    logic [2:0] ov;
    logic [2:0] ab;

    int checks   = 0;
    int failures = 0;

    localparam int WS[3] = '{8, 8, 4};
    localparam bit MF[3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    s2p_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .s2p_en(en), .data_in(din), .data_out_ready(rdy),
        .data_out(d0), .data_out_valid(v[0]), .overflow(ov[0]), .frame_abort(ab[0])
    );
    s2p_param #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .s2p_en(en), .data_in(din), .data_out_ready(rdy),
        .data_out(d1), .data_out_valid(v[1]), .overflow(ov[1]), .frame_abort(ab[1])
    );
    s2p_param #(.WIDTH(4), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .s2p_en(en), .data_in(din), .data_out_ready(rdy),
        .data_out(d2), .data_out_valid(v[2]), .overflow(ov[2]), .frame_abort(ab[2])
    );

    // Reference model state: bits of the current frame, output holding state,
    // and a scoreboard of words expected to be handed to the consumer.
    bit       bq   [3][$];
    bit [7:0] sbq  [3][$];
    bit [7:0] mdata[3];
    bit       mval [3];
    bit       mov  [3];
    bit       mab  [3];
    bit [7:0] mw;
    bit       macc;
    bit       mcmp;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dsel(input int c);
        case (c)
            0:       return d0;
            1:       return d1;
            default: return {4'b0, d2};
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                bq[c].delete();
                sbq[c].delete();
                mdata[c] = '0;
                mval[c]  = 1'b0;
                mov[c]   = 1'b0;
                mab[c]   = 1'b0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                mov[c] = 1'b0;
                mab[c] = 1'b0;
                macc   = mval[c] && rdy;
                mcmp   = 1'b0;
                if (en) begin
                    bq[c].push_back(din);
                    if (bq[c].size() == WS[c]) begin
                        mcmp = 1'b1;
                        mw   = '0;
                        for (int i = 0; i < WS[c]; i++) begin
                            if (MF[c]) mw[WS[c]-1-i] = bq[c][i];
                            else       mw[i]         = bq[c][i];
                        end
                        bq[c].delete();
                    end
                end else begin
                    if (bq[c].size() != 0) mab[c] = 1'b1;
                    bq[c].delete();
                end
                if (mcmp) begin
                    if (!mval[c] || macc) begin
                        mdata[c] = mw;
                        mval[c]  = 1'b1;
                        sbq[c].push_back(mw);
                    end else begin
                        mov[c] = 1'b1;
                    end
                end else if (macc) begin
                    mval[c] = 1'b0;
                end
            end
        end
    end

    // Monitor: per-cycle flag checks, and a scoreboard pop on every transfer.
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("valid%0d", c), 8'(v[c]), 8'(mval[c]));
            chk($sformatf("overflow%0d", c), 8'(ov[c]), 8'(mov[c]));
            chk($sformatf("abort%0d", c), 8'(ab[c]), 8'(mab[c]));
            chk($sformatf("data%0d", c), dsel(c), mdata[c]);
            if (v[c] && rdy) begin
                if (sbq[c].size() == 0) begin
                    chk($sformatf("sb_empty%0d", c), dsel(c), 8'hxx);
                end else begin
                    chk($sformatf("sb_word%0d", c), dsel(c), sbq[c].pop_front());
                end
            end
        end
    end

    task automatic drive(input logic e, input logic d, input logic r);
        en  = e;
        din = d;
        rdy = r;
        @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b1, bits[n-1-i], r);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        din = 1'b0;
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 8'(v), 8'h00);
        chk("rst_data0", d0, 8'h00);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1);

        // Bit order and latency
        send_bits(16'h00B2, 8, 1'b1);
        chk("order_msb", d0, 8'hB2);
        chk("order_lsb", d1, 8'h4D);
        chk("order_w4", {4'b0, d2}, 8'h02);
        chk("order_valid", 8'(v[0]), 8'h01);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);

        // Back-to-back nibbles
        send_bits(16'h0A5F, 12, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);

        // Backpressure
        send_bits(16'h003C, 8, 1'b0);
        chk("bp_hold", {4'b0, d2}, 8'h03);
        chk("bp_ovf", 8'(ov[2]), 8'h01);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        chk("bp_release", 8'(v[2]), 8'h00);
        drive(1'b0, 1'b0, 1'b1);

        // Accept and complete on the same edge
        send_bits(16'h0009, 4, 1'b0);
        send_bits(16'h0003, 3, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        chk("simul_data", {4'b0, d2}, 8'h06);
        chk("simul_valid", 8'(v[2]), 8'h01);
        chk("simul_ovf", 8'(ov[2]), 8'h00);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);

        // Aborted frame
        send_bits(16'h0005, 3, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        chk("abort_pulse", 8'(ab[0]), 8'h01);
        drive(1'b0, 1'b0, 1'b1);
        chk("abort_clear", 8'(ab[0]), 8'h00);
        send_bits(16'h005A, 8, 1'b1);
        chk("after_abort", d0, 8'h5A);
        drive(1'b0, 1'b0, 1'b1);

        // Reset mid-frame
        send_bits(16'h0013, 5, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 8'(v), 8'h00);
        chk("midrst_data", d0, 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b1;
        send_bits(16'h00C3, 8, 1'b1);
        chk("post_rst", d0, 8'hC3);
        drive(1'b0, 1'b0, 1'b1);

        // Randomized traffic
        repeat (3000) begin
            drive($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (4) drive(1'b0, 1'b0, 1'b1);

        for (int c = 0; c < 3; c++) begin
            chk($sformatf("sb_left%0d", c), 8'(sbq[c].size()), 8'h00);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
